div_share_ctrl: RTL
===================

# div_share_ctrl

Sequential front-end that shares one combinational `bit32_divider` between two requesters. It arbitrates round-robin, latches the winner's operands, and holds them stable for a programmable settle window so the long combinational divide path can be timed as a multicycle path. It then registers quotient, remainder and error, and returns them to the requester that issued the operation. It sits between the two client blocks and the single divider instance, which it instantiates internally.

## Interface
- `CALC_CYCLES`, default 2: clock cycles the operands are held on the divider before outputs are sampled (legal range 1..15).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid_0` / `req_valid_1` in 1: requester i has an operation pending.
- `req_ready_0` / `req_ready_1` out 1: controller accepts requester i this cycle.
- `dividend_0` / `dividend_1` in 32: dividend from requester i.
- `divisor_0` / `divisor_1` in 32: divisor from requester i.
- `signed_0` / `signed_1` in 1: 1 = two's-complement divide, 0 = unsigned. Drives the divider `s` input.
- `rsp_valid_0` / `rsp_valid_1` out 1: result for requester i is valid.
- `rsp_ready_0` / `rsp_ready_1` in 1: requester i consumes its result.
- `quotient` out 32: registered quotient, shared by both response channels.
- `remainder` out 32: registered remainder, shared by both response channels.
- `error` out 1: registered divide-by-zero flag.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states and transitions:
  - IDLE → CALC on a request handshake.
  - CALC → RESP when the settle counter expires.
  - RESP → IDLE on a response handshake (`rsp_valid_o & rsp_ready_o`, where o is the owner).
- Grant is combinational, in IDLE only:
  - If only one `req_valid` is high, that port is granted.
  - If both are high, port `rr_ptr` is granted.
  - `req_ready_i` = (state==IDLE) & grant==i. It is never high for both ports, and never high outside IDLE.
- Request handshake is `req_valid_i & req_ready_i`. On it:
  - Capture dividend, divisor and signed flag into operand registers.
  - Record owner = i.
  - Load settle counter with `CALC_CYCLES-1`.
- The operand registers feed the internal `bit32_divider` continuously. They change only on a request handshake, so the divider inputs are stable throughout CALC and RESP.
- CALC:
  - Decrement the counter each cycle.
  - On the cycle the counter reads 0, sample the divider outputs into `quotient`, `remainder` and `error`, and go to RESP.
- Divide-by-zero: when the divider `error` is 1, the controller registers quotient=0, remainder=0, error=1, independent of the divider's q/r outputs.
- Signed results truncate toward zero. The remainder takes the sign of the dividend, as produced by the divider.
- RESP: `rsp_valid_owner`=1 and the other port's `rsp_valid`=0. Results hold until the response handshake.
- On the response handshake, `rr_ptr` ← ~owner, so the other port has priority next.
- `rr_ptr` changes only on a response handshake.
- Only one operation is in flight. A second `req_valid` waits (no ready) until the FSM returns to IDLE.
- Requesters must hold `req_valid` and operands stable until ready. The controller does not check this.

## Timing
- Reset values (async, effective immediately):
  - state=IDLE, `rr_ptr`=0, counter=0.
  - All `rsp_valid`=0, `req_ready` as per IDLE grant, `busy`=0.
  - `quotient`=0, `remainder`=0, `error`=0, operand registers=0.
- Latency: request handshake at edge T → results and `rsp_valid` visible after edge T+`CALC_CYCLES`.
- Throughput with `rsp_ready` held high: one operation per `CALC_CYCLES`+2 cycles (accept cycle, settle window, response cycle).
- `rsp_ready` asserted before `rsp_valid` is legal. The handshake completes in the first RESP cycle.
- A new request arriving in the same cycle as a response handshake is not accepted that cycle. It is accepted in the following IDLE cycle.
- A `req_valid` asserted during CALC/RESP is accepted at the first IDLE cycle, subject to round-robin.
- Reset mid-operation: the operation is abandoned, no response is issued, and both requesters see `req_ready` only after reset deasserts.
- `CALC_CYCLES`=1: CALC lasts exactly one cycle.

## Test plan
- Unsigned single request, port 0, `CALC_CYCLES`=2: 183/14 → quotient=13, remainder=1, error=0. `rsp_valid_0` rises exactly 2 cycles after the accept edge. `rsp_valid_1` stays 0.
- Signed, port 1:
  - -892/67 → quotient=-13, remainder=-21.
  - 60000/-30 → quotient=-2000, remainder=0.
  - -9320634/-1274 → quotient=7316, remainder=-50.
- Divide by zero on port 0: 1/0 → error=1, quotient=0, remainder=0. The next request (1000/100) returns 10 r 0 with error=0.
- Contention: both ports valid continuously, `rsp_ready` high, 4 ops per port. Grants alternate 0,1,0,1…, starting with port 0 after reset. Each op takes 4 cycles (`CALC_CYCLES`=2). Ready is never high on both ports.
- Response backpressure: port 1 holds `rsp_ready_1`=0 for 5 cycles. Results and `rsp_valid_1` stay stable, and port 0's pending request gets no ready until port 1 consumes its result.
- Reset asserted in CALC: outputs return to reset values immediately, and no `rsp_valid` appears. After release, 467/13 completes with quotient=35, remainder=12.

Source files
------------

// File: rtl/div_share_ctrl.sv
// Purpose : shares one combinational 32-bit divider between two requesters (round-robin).
// Latency : results and rsp_valid appear CALC_CYCLES cycles after the accept edge.
// Backpr. : one op in flight; req_ready stays low until the owner consumes its response.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   req_valid_i/req_ready_i      request handshake, requester i (0/1)
//   dividend_i/divisor_i/signed_i operands from requester i
//   rsp_valid_i/rsp_ready_i      response handshake, requester i
//   quotient/remainder/error     registered result, shared by both response channels
//   busy                         high whenever an operation is in flight

// Combinational divider. Signed mode truncates toward zero; the remainder
// follows the sign of the dividend. Divide-by-zero forces q=r=0, error=1.
module bit32_divider (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        s,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        error
);
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] safe_b;
  logic [31:0] mag_q;
  logic [31:0] mag_r;

  always_comb begin
    error  = (b == 32'd0);
    neg_a  = s & a[31];
    neg_b  = s & b[31];
    mag_a  = neg_a ? (~a + 32'd1) : a;
    mag_b  = neg_b ? (~b + 32'd1) : b;
    // Keep the divide operator away from a zero divisor; the result is masked anyway.
    safe_b = error ? 32'd1 : mag_b;
    mag_q  = mag_a / safe_b;
    mag_r  = mag_a % safe_b;
    q      = 32'd0;
    r      = 32'd0;
    if (!error) begin
      q = (neg_a ^ neg_b) ? (~mag_q + 32'd1) : mag_q;
      r = neg_a ? (~mag_r + 32'd1) : mag_r;
    end
  end
endmodule

module div_share_ctrl #(
  parameter int unsigned CALC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_0,
  input  logic        req_valid_1,
  output logic        req_ready_0,
  output logic        req_ready_1,
  input  logic [31:0] dividend_0,
  input  logic [31:0] dividend_1,
  input  logic [31:0] divisor_0,
  input  logic [31:0] divisor_1,
  input  logic        signed_0,
  input  logic        signed_1,
  output logic        rsp_valid_0,
  output logic        rsp_valid_1,
  input  logic        rsp_ready_0,
  input  logic        rsp_ready_1,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        error,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(CALC_CYCLES - 1);

  state_t      state_q, state_d;
  logic        rr_q, rr_d;
  logic        owner_q, owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic        ops_q, ops_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic        err_q, err_d;

  logic        idle;
  logic        gnt_any;
  logic        gnt_idx;
  logic        req_hs;
  logic        rsp_hs;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic        div_err;

  // Operand registers drive the divider continuously; they only move on an
  // accept, so the divide path sees stable inputs for the whole CALC/RESP window.
  bit32_divider u_div (
    .a     (opa_q),
    .b     (opb_q),
    .s     (ops_q),
    .q     (div_q),
    .r     (div_r),
    .error (div_err)
  );

  always_comb begin
    idle    = (state_q == IDLE);
    gnt_any = req_valid_0 | req_valid_1;
    // Contention goes to rr_q; otherwise the single requester wins.
    gnt_idx = (req_valid_0 & req_valid_1) ? rr_q : req_valid_1;
    // rst_n gating keeps ready low while reset is held, not just after its release.
    req_ready_0 = rst_n & idle & gnt_any & ~gnt_idx;
    req_ready_1 = rst_n & idle & gnt_any &  gnt_idx;
    req_hs      = (req_valid_0 & req_ready_0) | (req_valid_1 & req_ready_1);
    rsp_valid_0 = (state_q == RESP) & ~owner_q;
    rsp_valid_1 = (state_q == RESP) &  owner_q;
    rsp_hs      = (rsp_valid_0 & rsp_ready_0) | (rsp_valid_1 & rsp_ready_1);
    busy        = ~idle;
    quotient    = quo_q;
    remainder   = rem_q;
    error       = err_q;
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    ops_d   = ops_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_hs) begin
          owner_d = gnt_idx;
          opa_d   = gnt_idx ? dividend_1 : dividend_0;
          opb_d   = gnt_idx ? divisor_1  : divisor_0;
          ops_d   = gnt_idx ? signed_1   : signed_0;
          cnt_d   = CNT_LOAD;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q == 4'd0) begin
          quo_d   = div_err ? 32'd0 : div_q;
          rem_d   = div_err ? 32'd0 : div_r;
          err_d   = div_err;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_hs) begin
          rr_d    = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= 4'd0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      ops_q   <= 1'b0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      ops_q   <= ops_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end
endmodule
